window_3x3_gen: RTL

//  Builds 3x3 signed pixel windows from a raster pixel stream, for the 3x3 convolution/sharpening

---
 rtl/window_3x3_gen_pkg.sv | 18 +
 rtl/window_3x3_gen_if.sv | 33 +++
 rtl/window_3x3_gen_line_buffer.sv | 24 ++
 rtl/window_3x3_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared types for the 3x3 window generator: pixel/window types and FSM states.
`timescale 1ns/1ps
package img_pkg;

  localparam int PIX_W = 9;

  typedef logic signed [PIX_W-1:0] pix_t;
  // win[row][col], [1][1] is the centre tap
  typedef pix_t [0:2][0:2] win_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    EOL   = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out handshake bundle. master = pixel source and window sink, slave = generator.
`timescale 1ns/1ps
interface window_3x3_gen_if #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
);
  import img_pkg::*;

  localparam int ORW = $clog2(IMG_H);
  localparam int OCW = $clog2(IMG_W);

  logic           s_valid;
  logic           s_ready;
  logic           s_sof;
  pix_t           s_pixel;
  logic           m_valid;
  logic           m_ready;
  win_t           m_win;
  logic [ORW-1:0] m_row;
  logic [OCW-1:0] m_col;
  logic           m_last;

  modport master (
    output s_valid, s_sof, s_pixel, m_ready,
    input  s_ready, m_valid, m_win, m_row, m_col, m_last
  );

  modport slave (
    input  s_valid, s_sof, s_pixel, m_ready,
    output s_ready, m_valid, m_win, m_row, m_col, m_last
  );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One line of pixel storage: shared read/write address, combinational read returns the old word.
`timescale 1ns/1ps
module line_buffer import img_pkg::*; #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 window generator over a raster pixel stream, one registered window per accept.
// Build option WIN_PAD_EN: zero-padded mode with one window centred on every pixel.
`timescale 1ns/1ps
module window_3x3_gen import img_pkg::*; #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  window_3x3_gen_if.slave bus
);

  localparam int AW  = $clog2(IMG_W);
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int ORW = $clog2(IMG_H);
  localparam int OCW = $clog2(IMG_W);
`ifdef WIN_PAD_EN
  localparam int FIRST  = 1;
  localparam int LAST_R = IMG_H - 1;
  localparam int LAST_C = IMG_W - 1;
`else
  localparam int FIRST  = 2;
  localparam int LAST_R = IMG_H - 2;
  localparam int LAST_C = IMG_W - 2;
`endif

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, cur_c, ctr_c;
  logic [RW-1:0]  row_q, row_d, cur_r, ctr_r;
  win_t           win_q, win_d, win_shift, win_out;
  logic           ready_en_q;
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
  win_t           out_win_q, out_win_d;
  logic [ORW-1:0] out_row_q, out_row_d;
  logic [OCW-1:0] out_col_q, out_col_d;
  logic           slot_free, s_ready, proc_pix, inject, step, emit;
  pix_t [0:2]     new_col;
  pix_t           lb0_rd, lb1_rd;

  assign slot_free = !out_valid_q || bus.m_ready;
  // Pixels arriving in IDLE without s_sof are accepted and discarded.
  assign proc_pix  = bus.s_valid && s_ready && (bus.s_sof || state_q == RUN);
`ifdef WIN_PAD_EN
  assign inject    = slot_free && (state_q == EOL || state_q == FLUSH);
`else
  assign inject    = 1'b0;
`endif
  assign step  = proc_pix || inject;
  assign cur_c = (proc_pix && bus.s_sof) ? '0 : col_q;
  assign cur_r = (proc_pix && bus.s_sof) ? '0 : row_q;
  assign ctr_c = cur_c - 1'b1;
  assign ctr_r = cur_r - 1'b1;
  assign emit  = step && (cur_r >= RW'(FIRST)) && (cur_c >= CW'(FIRST));

  line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb0 (
    .clk(clk), .we(proc_pix), .addr(AW'(cur_c)), .wdata(bus.s_pixel), .rdata(lb0_rd)
  );
  line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb1 (
    .clk(clk), .we(proc_pix), .addr(AW'(cur_c)), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    new_col = '0;
    if (proc_pix) begin
      new_col = {lb1_rd, lb0_rd, bus.s_pixel};
    end
`ifdef WIN_PAD_EN
    else if (state_q == FLUSH && col_q != CW'(IMG_W)) begin
      new_col[0] = lb1_rd;
      new_col[1] = lb0_rd;
    end
`endif
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_shift
    assign win_shift[gi] = {win_q[gi][1], win_q[gi][2], new_col[gi]};
  end
  assign win_d = step ? win_shift : win_q;

  always_comb begin
    win_out = win_shift;
`ifdef WIN_PAD_EN
    // Taps left of column 0 or above row 0 lie outside the frame.
    if (ctr_c == '0) begin
      for (int i = 0; i < 3; i++) win_out[i][0] = '0;
    end
    if (ctr_r == '0) begin
      win_out[0] = '0;
    end
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_win_d   = out_win_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_win_d   = win_out;
      out_row_d   = ORW'(ctr_r);
      out_col_d   = OCW'(ctr_c);
      out_last_d  = (ctr_r == RW'(LAST_R)) && (ctr_c == CW'(LAST_C));
    end else if (bus.m_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state and position counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (proc_pix) begin
      state_d = RUN;
      row_d   = cur_r;
      if (cur_c == CW'(IMG_W - 1)) begin
`ifdef WIN_PAD_EN
        col_d   = CW'(IMG_W);
        state_d = EOL;
`else
        col_d = '0;
        if (cur_r == RW'(IMG_H - 1)) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = cur_r + 1'b1;
        end
`endif
      end else begin
        col_d = cur_c + 1'b1;
      end
    end
`ifdef WIN_PAD_EN
    else if (inject) begin
      if (state_q == EOL) begin
        col_d = '0;
        if (row_q == RW'(IMG_H - 1)) begin
          row_d   = RW'(IMG_H);
          state_d = FLUSH;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = RUN;
        end
      end else if (col_q == CW'(IMG_W)) begin
        col_d   = '0;
        row_d   = '0;
        state_d = IDLE;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
`endif
  end

  // FSM: outputs
  always_comb begin
    s_ready = ready_en_q && slot_free && (state_q == IDLE || state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_win_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_win_q   <= out_win_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = out_valid_q;
  assign bus.m_win   = out_win_q;
  assign bus.m_row   = out_row_q;
  assign bus.m_col   = out_col_q;
  assign bus.m_last  = out_last_q;

endmodule
